// File: rtl/acumulador.sv
// Sums NUM_MUESTRAS 4-bit adder results into an 8-bit total, then holds it until downstream takes it.
// Optional macro ACUMULADOR_SATURATE_EN clamps the sum at 255 instead of wrapping modulo 256.
module acumulador #(
    parameter int NUM_MUESTRAS = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       enb,
    input  logic [3:0] c,
    input  logic       c_valid,
    output logic       c_ready,
    output logic [7:0] total,
    output logic       total_valid,
    input  logic       total_ready,
    output logic       desborde,
    output logic [4:0] cuenta
);

    typedef enum logic [1:0] {IDLE, ACUM, ENTREGA} estado_t;

    localparam logic [4:0] LP_N = 5'(NUM_MUESTRAS);

    estado_t    r_estado, w_estado_sig;
    logic [7:0] r_acc, r_total;
    logic [4:0] r_cuenta;
    logic       r_total_valid, r_desborde;

    logic       w_acepta, w_libera, w_ultimo, w_desb_sig;
    logic [8:0] w_suma;
    logic [7:0] w_acc_sig;
    logic [4:0] w_cuenta_sig;

    always_comb begin
        c_ready      = reset_L && enb && (r_estado != ENTREGA);
        w_acepta     = c_valid && c_ready;
        w_libera     = enb && total_ready && (r_estado == ENTREGA);
        w_cuenta_sig = (r_estado == IDLE) ? 5'd1 : r_cuenta + 5'd1;
        // Starting a block adds to zero, so IDLE and ACUM share one adder.
        w_suma       = {1'b0, (r_estado == IDLE) ? 8'd0 : r_acc} + {5'd0, c};
        w_desb_sig   = ((r_estado == ACUM) && r_desborde) || w_suma[8];
`ifdef ACUMULADOR_SATURATE_EN
        w_acc_sig    = w_suma[8] ? 8'hFF : w_suma[7:0];
`else
        w_acc_sig    = w_suma[7:0];
`endif
        w_ultimo     = (w_cuenta_sig == LP_N);

        w_estado_sig = r_estado;
        case (r_estado)
            IDLE, ACUM: if (w_acepta) w_estado_sig = w_ultimo ? ENTREGA : ACUM;
            ENTREGA:    if (w_libera) w_estado_sig = IDLE;
            default:    w_estado_sig = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) r_estado <= IDLE;
        else          r_estado <= w_estado_sig;
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_acc         <= 8'd0;
            r_total       <= 8'd0;
            r_cuenta      <= 5'd0;
            r_total_valid <= 1'b0;
            r_desborde    <= 1'b0;
        end else if (w_acepta) begin
            r_acc      <= w_acc_sig;
            r_cuenta   <= w_cuenta_sig;
            r_desborde <= w_desb_sig;
            if (w_ultimo) begin
                r_total       <= w_acc_sig;
                r_total_valid <= 1'b1;
            end
        end else if (w_libera) begin
            r_total_valid <= 1'b0;
            r_cuenta      <= 5'd0;
        end
    end

    assign total       = r_total;
    assign total_valid = r_total_valid;
    assign desborde    = r_desborde;
    assign cuenta      = r_cuenta;

endmodule

// File: tb/tb_acumulador.sv
// Drives three acumulador instances (NUM_MUESTRAS = 1, 4, 20) with shared stimulus and
// compares each against a sum-of-samples reference model every cycle.
module tb_acumulador;

`ifdef ACUMULADOR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_L, enb, c_valid, total_ready;
    logic [3:0] c;

    logic       o_c_ready [3];
    logic [7:0] o_total   [3];
    logic       o_tv      [3];
    logic       o_desb    [3];
    logic [4:0] o_cuenta  [3];

    always #5 clk = ~clk;

    acumulador #(.NUM_MUESTRAS(1)) u_n1 (
        .clk(clk), .reset_L(reset_L), .enb(enb), .c(c), .c_valid(c_valid),
        .c_ready(o_c_ready[0]), .total(o_total[0]), .total_valid(o_tv[0]),
        .total_ready(total_ready), .desborde(o_desb[0]), .cuenta(o_cuenta[0]));

    acumulador #(.NUM_MUESTRAS(4)) u_n4 (
        .clk(clk), .reset_L(reset_L), .enb(enb), .c(c), .c_valid(c_valid),
        .c_ready(o_c_ready[1]), .total(o_total[1]), .total_valid(o_tv[1]),
        .total_ready(total_ready), .desborde(o_desb[1]), .cuenta(o_cuenta[1]));

    acumulador #(.NUM_MUESTRAS(20)) u_n20 (
        .clk(clk), .reset_L(reset_L), .enb(enb), .c(c), .c_valid(c_valid),
        .c_ready(o_c_ready[2]), .total(o_total[2]), .total_valid(o_tv[2]),
        .total_ready(total_ready), .desborde(o_desb[2]), .cuenta(o_cuenta[2]));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: samples taken in the block, their true integer sum, and the delivered result.
    int m_cnt   [3];
    int m_sum   [3];
    int m_total [3];
    bit m_ent   [3];
    bit m_desb  [3];

    function automatic int nm(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 4 : 20);
    endfunction

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_tests++;
        if (obs !== esp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, esp);
        end
    endtask

    task automatic paso(input logic rl, input logic en, input logic cv,
                        input logic [3:0] cd, input logic tr);
        reset_L     = rl;
        enb         = en;
        c_valid     = cv;
        c           = cd;
        total_ready = tr;
        #1;
        for (int k = 0; k < 3; k++)
            chequear($sformatf("N%0d.c_ready", nm(k)), 32'(o_c_ready[k]),
                     32'(rl && en && !m_ent[k]));
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rl) begin
                m_cnt[k] = 0; m_sum[k] = 0; m_total[k] = 0; m_ent[k] = 0; m_desb[k] = 0;
            end else if (en) begin
                if (m_ent[k]) begin
                    if (tr) begin
                        m_ent[k] = 0;
                        m_cnt[k] = 0;
                    end
                end else if (cv) begin
                    if (m_cnt[k] == 0) m_sum[k] = 0;
                    m_sum[k]  = m_sum[k] + int'(cd);
                    m_cnt[k]  = m_cnt[k] + 1;
                    m_desb[k] = (m_sum[k] > 255);
                    if (m_cnt[k] == nm(k)) begin
                        m_ent[k]   = 1;
                        m_total[k] = SAT ? ((m_sum[k] > 255) ? 255 : m_sum[k]) : (m_sum[k] % 256);
                    end
                end
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chequear($sformatf("N%0d.total", nm(k)),       32'(o_total[k]),  32'(m_total[k]));
            chequear($sformatf("N%0d.total_valid", nm(k)), 32'(o_tv[k]),     32'(m_ent[k]));
            chequear($sformatf("N%0d.desborde", nm(k)),    32'(o_desb[k]),   32'(m_desb[k]));
            chequear($sformatf("N%0d.cuenta", nm(k)),      32'(o_cuenta[k]), 32'(m_cnt[k]));
        end
    endtask

    task automatic reiniciar();
        paso(1'b0, 1'b1, 1'b1, 4'd7, 1'b1);
    endtask

    initial begin
        logic [3:0] sec_a [4];
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_sum[k] = 0; m_total[k] = 0; m_ent[k] = 0; m_desb[k] = 0;
        end

        // Reset state, with enb and c_valid asserted to show reset wins.
        reiniciar();
        reiniciar();
        chequear("rst.total",  32'(o_total[1]),  32'd0);
        chequear("rst.cuenta", 32'(o_cuenta[1]), 32'd0);
        chequear("rst.tv",     32'(o_tv[1]),     32'd0);
        enb = 1'b1; reset_L = 1'b1; #1;
        chequear("post_rst.c_ready", 32'(o_c_ready[1]), 32'd1);

        // 1,2,3,4 -> 10, valid right after the 4th sample.
        sec_a = '{4'd1, 4'd2, 4'd3, 4'd4};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chequear("sum10.tv_early", 32'(o_tv[1]), 32'd0);
            paso(1'b1, 1'b1, 1'b1, sec_a[i], 1'b1);
        end
        chequear("sum10.total", 32'(o_total[1]), 32'd10);
        chequear("sum10.tv",    32'(o_tv[1]),    32'd1);
        chequear("sum10.desb",  32'(o_desb[1]),  32'd0);
        paso(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);

        // 20 x 15 = 300: wraps to 44 or clamps to 255.
        reiniciar();
        for (int i = 0; i < 20; i++) paso(1'b1, 1'b1, 1'b1, 4'd15, 1'b1);
        chequear("ovf.total", 32'(o_total[2]), SAT ? 32'd255 : 32'd44);
        chequear("ovf.desb",  32'(o_desb[2]),  32'd1);
        chequear("ovf.tv",    32'(o_tv[2]),    32'd1);
        paso(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);

        // Backpressure: held result, no samples consumed.
        reiniciar();
        for (int i = 0; i < 4; i++) paso(1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 5; i++) begin
            paso(1'b1, 1'b1, 1'b1, 4'd9, 1'b0);
            chequear("bp.total",  32'(o_total[1]),  32'd12);
            chequear("bp.cuenta", 32'(o_cuenta[1]), 32'd4);
        end
        paso(1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        chequear("bp.tv_off", 32'(o_tv[1]),    32'd0);
        chequear("bp.hold",   32'(o_total[1]), 32'd12);
        paso(1'b1, 1'b1, 1'b1, 4'd2, 1'b1);
        chequear("bp.fresh",  32'(o_cuenta[1]), 32'd1);

        // enb=0 gap after the 2nd sample.
        reiniciar();
        paso(1'b1, 1'b1, 1'b1, 4'd5, 1'b1);
        paso(1'b1, 1'b1, 1'b1, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            paso(1'b1, 1'b0, 1'b1, 4'd7, 1'b1);
            chequear("enb.cuenta", 32'(o_cuenta[1]), 32'd2);
        end
        paso(1'b1, 1'b1, 1'b1, 4'd7, 1'b1);
        paso(1'b1, 1'b1, 1'b1, 4'd2, 1'b1);
        chequear("enb.total", 32'(o_total[1]), 32'd14);

        // Reset mid-block discards the partial sum.
        reiniciar();
        paso(1'b1, 1'b1, 1'b1, 4'd6, 1'b1);
        paso(1'b1, 1'b1, 1'b1, 4'd6, 1'b1);
        reiniciar();
        for (int i = 0; i < 4; i++) begin
            chequear("rstmid.tv_early", 32'(o_tv[1]), 32'd0);
            paso(1'b1, 1'b1, 1'b1, 4'd1, 1'b0);
        end
        chequear("rstmid.total",  32'(o_total[1]),  32'd4);
        chequear("rstmid.cuenta", 32'(o_cuenta[1]), 32'd4);

        // Single-sample blocks go straight to delivery.
        reiniciar();
        paso(1'b1, 1'b1, 1'b1, 4'd9, 1'b0);
        chequear("n1.total", 32'(o_total[0]), 32'd9);
        chequear("n1.tv",    32'(o_tv[0]),    32'd1);
        #1;
        chequear("n1.c_ready", 32'(o_c_ready[0]), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++)
            paso(logic'($urandom_range(0, 63) != 0), logic'($urandom_range(0, 7) != 0),
                 logic'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                 logic'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/acumulador.md
ACUMULADOR -- requirements
Module: acumulador

Interface
REQ-001 The block SHALL have parameter NUM_MUESTRAS, default 4, meaning the number of adder results summed per block; legal range 1..31.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_L  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port enb  input  1  global enable; when 0, all state and outputs hold.
REQ-005 The block SHALL have port c  input  4  unsigned result from the upstream 4-bit adder.
REQ-006 The block SHALL have port c_valid  input  1  c is valid this cycle.
REQ-007 The block SHALL have port c_ready  output  1  the block accepts c this cycle.
REQ-008 The block SHALL have port total  output  8  accumulated block sum.
REQ-009 The block SHALL have port total_valid  output  1  total is valid and held.
REQ-010 The block SHALL have port total_ready  input  1  the downstream consumer takes total.
REQ-011 The block SHALL have port desborde  output  1  overflow occurred in the current or delivered block.
REQ-012 The block SHALL have port cuenta  output  5  number of samples accepted in the current block.

Function
REQ-013 The FSM SHALL have three states: IDLE, ACUM and ENTREGA.
REQ-014 Acceptance SHALL occur when enb=1, c_valid=1 and c_ready=1; c_ready SHALL be 1 in IDLE and ACUM, and 0 in ENTREGA.
REQ-015 On acceptance in IDLE: acc<=c, cuenta<=1, desborde<=0; next state ACUM, or ENTREGA if NUM_MUESTRAS=1.
REQ-016 On acceptance in ACUM: acc<=acc+c (9-bit internal sum), cuenta<=cuenta+1; a carry out of bit 7 SHALL set desborde (sticky for the block).
REQ-017 When the acceptance making cuenta equal NUM_MUESTRAS occurs, the next state SHALL be ENTREGA, with total_valid=1 and total=final acc on the following cycle (1-cycle latency).
REQ-018 Without acceptance in IDLE or ACUM, acc, cuenta and the state SHALL hold, regardless of gaps between samples.
REQ-019 In ENTREGA, total, desborde and cuenta SHALL stay stable while total_ready=0 (backpressure, unbounded).
REQ-020 In ENTREGA with enb=1 and total_ready=1: next state IDLE, total_valid<=0, cuenta<=0; total and desborde SHALL hold their last values until the next IDLE acceptance.
REQ-021 There SHALL be no same-cycle return from ENTREGA to accumulation; the first sample of the next block is accepted no earlier than the cycle after release.
REQ-022 total_ready SHALL be ignored outside ENTREGA; c_valid SHALL be ignored in ENTREGA.
REQ-023 When enb=0, the FSM, acc, cuenta, total, total_valid and desborde SHALL hold; c_ready SHALL be 0.

Reset
REQ-024 With reset_L=0 at a rising edge: state<=IDLE; acc, total, cuenta<=0; total_valid, desborde<=0. Reset SHALL take priority over enb and all handshakes.
REQ-025 A reset asserted mid-block or during ENTREGA SHALL discard the partial or pending sum; no total_valid pulse SHALL follow.
REQ-026 c_ready SHALL be 0 during reset and 1 on the first cycle after reset release when enb=1.

Configuration
REQ-027 With macro ACUMULADOR_SATURATE_EN defined, an ACUM addition whose 9-bit sum exceeds 255 SHALL load acc=255; acc SHALL stay 255 for the rest of the block, and desborde SHALL be set.
REQ-028 With ACUMULADOR_SATURATE_EN undefined, acc SHALL wrap modulo 256 and desborde SHALL be set on carry.

Verification
REQ-029 The bench SHALL cover: NUM_MUESTRAS=4, c=1,2,3,4 on consecutive cycles -> total=10, total_valid=1 one cycle after the 4th sample, desborde=0.
REQ-030 The bench SHALL cover: NUM_MUESTRAS=20, c=15 x20 -> total=44 with desborde=1 (wrap), or total=255 with desborde=1 when ACUMULADOR_SATURATE_EN is defined.
REQ-031 The bench SHALL cover: a block complete, total_ready=0 for 5 cycles with c_valid=1 -> total stable, c_ready=0, no sample consumed; total_ready=1 -> total_valid=0 next cycle.
REQ-032 The bench SHALL cover: NUM_MUESTRAS=4, c=5,0,7,2 with enb=0 for 3 cycles after the 2nd sample -> cuenta holds 2, total=14.
REQ-033 The bench SHALL cover: reset_L=0 after 2 of 4 samples, then 4 new samples c=1 -> total=4, cuenta=4, no earlier total_valid.
REQ-034 The bench SHALL cover: NUM_MUESTRAS=1, c=9 -> state goes directly to ENTREGA, total=9 one cycle later.
